sram_port_master: RTL and testbench
===================================

SRAM_PORT_MASTER -- requirements
Module: sram_port_master

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 2048, number of SRAM words; address width AW = $clog2(DEPTH).
REQ-003 SHALL have parameter INIT_EN, default 1; 1 = zero-fill the SRAM after reset.
REQ-004 SHALL have one clock and one reset, asynchronous active-low: clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  request offered.
REQ-007 req_ready  out  1  request accepted when high with req_valid.
REQ-008 req_wr  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  AW  request address.
REQ-010 req_wdata  in  WIDTH  write data.
REQ-011 rsp_valid  out  1  read data available.
REQ-012 rsp_ready  in  1  consumer takes read data.
REQ-013 rsp_rdata  out  WIDTH  read data, in request order.
REQ-014 init_done  out  1  zero-fill complete; requests allowed.
REQ-015 sram_addr  out  AW  to SRAM address port.
REQ-016 sram_rd_o_wr  out  1  to SRAM: 1 write, 0 read.
REQ-017 sram_i_data  out  WIDTH  to SRAM write data.
REQ-018 sram_o_data  in  WIDTH  from SRAM registered read data (valid one cycle after read edge, updates every non-write cycle).

Function
REQ-019 FSM SHALL have states INIT and RUN; reset enters INIT if INIT_EN=1, else RUN.
REQ-020 In INIT: sram_rd_o_wr=1, sram_i_data=0, sram_addr=init counter starting at 0, incrementing each cycle; req_ready=0.
REQ-021 INIT SHALL exit to RUN on the edge writing address DEPTH-1; init_done rises on that same edge (exactly DEPTH write cycles).
REQ-022 In RUN, SRAM port is driven combinationally from the request: on accept, sram_addr=req_addr, sram_rd_o_wr=req_wr, sram_i_data=req_wdata; otherwise sram_rd_o_wr=0, sram_addr=0, sram_i_data=0.
REQ-023 Accept = req_valid && req_ready; writes produce no response.
REQ-024 Accepted read at edge N sets an in-flight flag; at edge N+1 sram_o_data is pushed into a 2-entry response FIFO; rsp_valid first observable after edge N+1 (latency 2 edges from accept to pop eligibility).
REQ-025 rsp_valid = FIFO not empty; rsp_rdata = FIFO head; pop = rsp_valid && rsp_ready.
REQ-026 Occupancy = in-flight + FIFO count; req_ready = RUN && (occupancy - pop) < 2 (combinational on rsp_ready), giving 1 read/cycle when rsp_ready held high.
REQ-027 Simultaneous push and pop SHALL keep count unchanged and preserve order; push to full FIFO cannot occur by REQ-026.
REQ-028 Writes are always accepted in RUN when REQ-026 permits; write after read to same address returns the old data for the read.
REQ-029 Backpressure (rsp_ready=0) SHALL hold rsp_rdata stable until popped.

Reset
REQ-030 On rst_n low: state=INIT (or RUN), init counter=0, in-flight=0, FIFO empty, init_done=0 (1 if INIT_EN=0), rsp_valid=0, req_ready=0, sram_rd_o_wr=0.
REQ-031 Reset mid-INIT SHALL restart zero-fill from address 0; reset mid-RUN SHALL discard in-flight and buffered reads.

Structure
REQ-032 State encoding (INIT, RUN) SHALL live in a shared package with other DDRFSM controller enums.
REQ-033 The 2-entry response FIFO SHALL be a sub-module named rsp_fifo2 (parameter WIDTH).

Verification (bench with DEPTH=16, WIDTH=8, paired with the team SRAM model)
REQ-034 Release reset -> 16 consecutive writes of 0 to addrs 0..15, init_done=1 after 16th edge, req_ready=0 throughout.
REQ-035 Write 0xA5 to addr 3, then read addr 3 -> rsp_valid two edges after read accept, rsp_rdata=0xA5.
REQ-036 Back-to-back reads of addrs 1,2,3 (preloaded 0x11,0x22,0x33) with rsp_ready=1 -> req_ready stays 1, responses 0x11,0x22,0x33 on consecutive cycles.
REQ-037 rsp_ready=0, issue 3 reads -> 2 accepted, req_ready=0, rsp_rdata held; raise rsp_ready -> third accepted, order preserved.
REQ-038 Same-cycle read addr 5 then next-cycle write 0x77 to addr 5 -> read returns prior value 0x00.
REQ-039 Assert rst_n low at init counter=7 -> after release, fill restarts at addr 0, init_done after 16 cycles.

Source files
------------

// File: rtl/sram_port_master_pkg.sv
// Shared encodings for the DDRFSM family of sequencing controllers.
// Holds the SRAM port master state codes and a small occupancy helper.
package sram_port_master_pkg;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef enum logic [1:0] {
        DDR_IDLE = 2'd0,
        DDR_ACT  = 2'd1,
        DDR_RW   = 2'd2,
        DDR_PRE  = 2'd3
    } ddr_cmd_t;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_kind_t;

    // Room for one more read once this cycle's pop (if any) is taken into account.
    function automatic logic has_room(input logic [2:0] occ, input logic pop);
        return (occ - {2'b00, pop}) < 3'd2;
    endfunction

endpackage

// File: rtl/rsp_fifo2.sv
// Two-entry response FIFO; simultaneous push and pop keeps the count and order.
module rsp_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             pop_ok;

    assign valid  = (count != 2'd0);
    assign head   = mem[rd_ptr];
    assign pop_ok = pop && valid;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_port_master.sv
// Request/response front end for a single-port SRAM with registered read data,
// including an optional zero-fill sweep after reset.
//   state | meaning
//   INIT  | writing zeros to every address, requests blocked
//   RUN   | forwarding requests, reads returned through rsp_fifo2
module sram_port_master
    import sram_port_master_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 2048,
    parameter int INIT_EN = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             init_done,
    output logic [AW-1:0]    sram_addr,
    output logic             sram_rd_o_wr,
    output logic [WIDTH-1:0] sram_i_data,
    input  logic [WIDTH-1:0] sram_o_data
);

    localparam logic [0:0]    ST_RESET = (INIT_EN != 0) ? ST_INIT : ST_RUN;
    localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);

    logic [0:0]    state_q;
    logic [AW-1:0] init_cnt;
    logic          inflight_q;
    logic [1:0]    fifo_count;
    logic [2:0]    occ;
    logic          pop;
    logic          accept;
    logic          in_init;

    // rst_n gating keeps the SRAM port quiet and requests blocked while reset is held.
    assign in_init   = (state_q == ST_INIT) && rst_n;
    assign init_done = (state_q == ST_RUN);
    assign occ       = {2'b00, inflight_q} + {1'b0, fifo_count};
    assign pop       = rsp_valid && rsp_ready;
    assign req_ready = (state_q == ST_RUN) && rst_n && has_room(occ, pop);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RESET;
            init_cnt   <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= accept && !req_wr;
            if (state_q == ST_INIT) begin
                if (init_cnt == LAST) begin
                    state_q <= ST_RUN;
                end else begin
                    init_cnt <= init_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        sram_addr    = '0;
        sram_rd_o_wr = 1'b0;
        sram_i_data  = '0;
        if (in_init) begin
            sram_addr    = init_cnt;
            sram_rd_o_wr = 1'b1;
        end else if (accept) begin
            sram_addr    = req_addr;
            sram_rd_o_wr = req_wr;
            sram_i_data  = req_wdata;
        end
    end

    rsp_fifo2 #(
        .WIDTH (WIDTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (sram_o_data),
        .pop       (pop),
        .valid     (rsp_valid),
        .head      (rsp_rdata),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_sram_port_master.sv
// Bench for sram_port_master with DEPTH=16, WIDTH=8 and a behavioural SRAM
// whose contents are scrambled on every reset so the zero-fill is observable.
module tb_sram_port_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_wr = 1'b0;
    logic [3:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_rdata;
    logic       init_done;
    logic [3:0] sram_addr;
    logic       sram_rd_o_wr;
    logic [7:0] sram_i_data;
    logic [7:0] sram_o_data;

    logic       scramble = 1'b0;
    logic [7:0] sram_mem [16];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_port_master #(
        .WIDTH   (8),
        .DEPTH   (16),
        .INIT_EN (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .init_done    (init_done),
        .sram_addr    (sram_addr),
        .sram_rd_o_wr (sram_rd_o_wr),
        .sram_i_data  (sram_i_data),
        .sram_o_data  (sram_o_data)
    );

    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < 16; i++) sram_mem[i] <= 8'($urandom) | 8'h01;
        end else if (sram_rd_o_wr) begin
            sram_mem[sram_addr] <= sram_i_data;
        end else begin
            sram_o_data <= sram_mem[sram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a negedge; leaves reset released just after a later negedge.
    task automatic apply_reset();
        req_valid = 1'b0;
        rst_n     = 1'b0;
        scramble  = 1'b1;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_sram_wr", sram_rd_o_wr, 0);
        chk("rst_init_done", init_done, 0);
        @(negedge clk);
        scramble = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Requests are offered throughout the fill and must be ignored.
    task automatic check_init();
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 4'd9;
        req_wdata = 8'hEE;
        for (int i = 0; i < 16; i++) begin
            chk("init_wr", sram_rd_o_wr, 1);
            chk("init_addr", sram_addr, i);
            chk("init_data", sram_i_data, 0);
            chk("init_req_ready", req_ready, 0);
            chk("init_done_low", init_done, 0);
            @(negedge clk);
            #1;
        end
        chk("init_done_high", init_done, 1);
        chk("run_req_ready", req_ready, 1);
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic       v;
        logic       wr;
        logic [3:0] a;
        logic [7:0] d;
        logic       rr;
        logic       e_rdy;
        logic       e_val;
        logic [7:0] e_dat;
        logic       e_swr;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic wr, input logic [3:0] a,
                                input logic [7:0] d, input logic rr, input logic e_rdy,
                                input logic e_val, input logic [7:0] e_dat, input logic e_swr);
        vec_t r;
        r.v = v; r.wr = wr; r.a = a; r.d = d; r.rr = rr;
        r.e_rdy = e_rdy; r.e_val = e_val; r.e_dat = e_dat; r.e_swr = e_swr;
        return r;
    endfunction

    typedef struct {
        logic [7:0] data;
        int         vis;
    } exp_t;

    logic [7:0] ref_mem [16];
    exp_t       q[$];
    int         cyc;

    // Reference: a read accepted in cycle c is poppable from cycle c+2; reads not yet
    // popped occupy the two response slots.
    task automatic rand_step(input bit allow);
        logic exp_val, exp_pop, exp_rdy;
        req_valid = allow ? 1'($urandom_range(0, 1)) : 1'b0;
        req_wr    = 1'($urandom_range(0, 1));
        req_addr  = 4'($urandom_range(0, 15));
        req_wdata = 8'($urandom);
        rsp_ready = allow ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        exp_val = (q.size() > 0) && (q[0].vis <= cyc);
        exp_pop = exp_val && rsp_ready;
        exp_rdy = (q.size() - (exp_pop ? 1 : 0)) < 2;
        chk("rand_rsp_valid", rsp_valid, exp_val);
        chk("rand_req_ready", req_ready, exp_rdy);
        if (exp_val) chk("rand_rsp_rdata", rsp_rdata, q[0].data);
        if (exp_pop) q.delete(0);
        if (req_valid && exp_rdy) begin
            chk("rand_sram_wr", sram_rd_o_wr, req_wr);
            chk("rand_sram_addr", sram_addr, req_addr);
            if (req_wr) ref_mem[req_addr] = req_wdata;
            else q.push_back('{data: ref_mem[req_addr], vis: cyc + 2});
        end else begin
            chk("rand_sram_idle", sram_rd_o_wr, 0);
        end
        cyc++;
        @(negedge clk);
    endtask

    vec_t tbl[30];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(1, 1, 3, 8'hA5, 1, 1, 0, 8'h00, 1);
        tbl[1]  = mk(1, 0, 3, 8'h00, 1, 1, 0, 8'h00, 0);
        tbl[2]  = mk(0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0);
        tbl[3]  = mk(0, 0, 0, 8'h00, 0, 1, 1, 8'hA5, 0);
        tbl[4]  = mk(0, 0, 0, 8'h00, 1, 1, 1, 8'hA5, 0);
        tbl[5]  = mk(1, 1, 1, 8'h11, 1, 1, 0, 8'h00, 1);
        tbl[6]  = mk(1, 1, 2, 8'h22, 1, 1, 0, 8'h00, 1);
        tbl[7]  = mk(1, 1, 3, 8'h33, 1, 1, 0, 8'h00, 1);
        tbl[8]  = mk(1, 0, 1, 8'h00, 1, 1, 0, 8'h00, 0);
        tbl[9]  = mk(1, 0, 2, 8'h00, 1, 1, 0, 8'h00, 0);
        tbl[10] = mk(1, 0, 3, 8'h00, 1, 1, 1, 8'h11, 0);
        tbl[11] = mk(0, 0, 0, 8'h00, 1, 1, 1, 8'h22, 0);
        tbl[12] = mk(0, 0, 0, 8'h00, 1, 1, 1, 8'h33, 0);
        tbl[13] = mk(0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0);
        tbl[14] = mk(1, 0, 1, 8'h00, 0, 1, 0, 8'h00, 0);
        tbl[15] = mk(1, 0, 2, 8'h00, 0, 1, 0, 8'h00, 0);
        tbl[16] = mk(1, 0, 3, 8'h00, 0, 0, 1, 8'h11, 0);
        tbl[17] = mk(1, 0, 3, 8'h00, 0, 0, 1, 8'h11, 0);
        tbl[18] = mk(1, 0, 3, 8'h00, 1, 1, 1, 8'h11, 0);
        tbl[19] = mk(0, 0, 0, 8'h00, 1, 1, 1, 8'h22, 0);
        tbl[20] = mk(0, 0, 0, 8'h00, 1, 1, 1, 8'h33, 0);
        tbl[21] = mk(0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0);
        tbl[22] = mk(1, 0, 5, 8'h00, 1, 1, 0, 8'h00, 0);
        tbl[23] = mk(1, 1, 5, 8'h77, 1, 1, 0, 8'h00, 1);
        tbl[24] = mk(0, 0, 0, 8'h00, 1, 1, 1, 8'h00, 0);
        tbl[25] = mk(0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0);
        tbl[26] = mk(1, 0, 5, 8'h00, 1, 1, 0, 8'h00, 0);
        tbl[27] = mk(0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0);
        tbl[28] = mk(0, 0, 0, 8'h00, 1, 1, 1, 8'h77, 0);
        tbl[29] = mk(0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0);

        // Reset, abandon the fill at address 7, then a full fill from address 0.
        @(negedge clk);
        apply_reset();
        chk("fill_start_addr", sram_addr, 0);
        repeat (7) @(negedge clk);
        #1;
        chk("mid_init_addr", sram_addr, 7);
        apply_reset();
        check_init();
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;

        for (int i = 0; i < 30; i++) begin
            req_valid = tbl[i].v;
            req_wr    = tbl[i].wr;
            req_addr  = tbl[i].a;
            req_wdata = tbl[i].d;
            rsp_ready = tbl[i].rr;
            #1;
            chk($sformatf("tbl%0d_req_ready", i), req_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_rsp_valid", i), rsp_valid, tbl[i].e_val);
            if (tbl[i].e_val) chk($sformatf("tbl%0d_rsp_rdata", i), rsp_rdata, tbl[i].e_dat);
            chk($sformatf("tbl%0d_sram_wr", i), sram_rd_o_wr, tbl[i].e_swr);
            if (tbl[i].v && tbl[i].e_rdy) chk($sformatf("tbl%0d_sram_addr", i), sram_addr, tbl[i].a);
            if (tbl[i].v && tbl[i].wr && tbl[i].e_rdy) ref_mem[tbl[i].a] = tbl[i].d;
            @(negedge clk);
        end

        cyc = 0;
        q.delete();
        for (int i = 0; i < 500; i++) rand_step(1'b1);
        for (int i = 0; i < 8; i++) rand_step(1'b0);
        chk("drain_model_empty", q.size(), 0);

        // Reset with a read buffered must drop it and rerun the fill.
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 4'd3;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("run_buffered_valid", rsp_valid, 1);
        apply_reset();
        check_init();
        @(negedge clk);
        #1;
        chk("post_reset_rsp_valid", rsp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
